// File: rtl/vga_pkg.sv
// Shared types and default timing for the VGA stream output block.
// Defaults describe an 800x480 panel with active-low syncs.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_ARMED,
        ST_RUN
    } stream_state_e;

    localparam int DEF_HDISP  = 800;
    localparam int DEF_VDISP  = 480;
    localparam int DEF_HFP    = 40;
    localparam int DEF_HPULSE = 48;
    localparam int DEF_HBP    = 40;
    localparam int DEF_VFP    = 13;
    localparam int DEF_VPULSE = 3;
    localparam int DEF_VBP    = 29;

    localparam int DEF_DATA_WIDTH = 32;
    localparam bit DEF_HS_POL     = 1'b0;
    localparam bit DEF_VS_POL     = 1'b0;

    localparam logic [DEF_DATA_WIDTH-1:0] DEF_FILL_COLOR = '0;

endpackage

// File: rtl/vga_timing.sv
// Raster counters and registered sync/blank/coordinate generation.
// Each line and frame runs front porch, pulse, back porch, then active area.
module vga_timing
    import vga_pkg::*;
#(
    parameter int HDISP  = DEF_HDISP,
    parameter int VDISP  = DEF_VDISP,
    parameter int HFP    = DEF_HFP,
    parameter int HPULSE = DEF_HPULSE,
    parameter int HBP    = DEF_HBP,
    parameter int VFP    = DEF_VFP,
    parameter int VPULSE = DEF_VPULSE,
    parameter int VBP    = DEF_VBP,
    parameter bit HS_POL = DEF_HS_POL,
    parameter bit VS_POL = DEF_VS_POL
) (
    input  logic                       pixel_clk,
    input  logic                       pixel_rst_n,
    output logic                       active_now,
    output logic                       first_now,
    output logic                       hs,
    output logic                       vs,
    output logic                       blank,
    output logic [$clog2(HDISP)-1:0]   pix_x,
    output logic [$clog2(VDISP)-1:0]   pix_y,
    output logic                       frame_start
);

    localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
    localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
    localparam int HSTART = HFP + HPULSE + HBP;
    localparam int VSTART = VFP + VPULSE + VBP;
    localparam int HC_W   = $clog2(HTOTAL);
    localparam int VC_W   = $clog2(VTOTAL);
    localparam int PX_W   = $clog2(HDISP);
    localparam int PY_W   = $clog2(VDISP);

    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    logic            h_wrap;
    logic            hs_now;
    logic            vs_now;

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        h_wrap     = (hc == HC_W'(HTOTAL - 1));
        hs_now     = (hc >= HC_W'(HFP)) && (hc < HC_W'(HFP + HPULSE));
        vs_now     = (vc >= VC_W'(VFP)) && (vc < VC_W'(VFP + VPULSE));
        active_now = (hc >= HC_W'(HSTART)) && (vc >= VC_W'(VSTART));
        first_now  = (hc == HC_W'(HSTART)) && (vc == VC_W'(VSTART));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same old values.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            hc          <= '0;
            vc          <= '0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            blank       <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            if (h_wrap) begin
                hc <= '0;
                vc <= (vc == VC_W'(VTOTAL - 1)) ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
            // Outputs describe the counter value of this cycle, one cycle late.
            hs          <= hs_now ? HS_POL : ~HS_POL;
            vs          <= vs_now ? VS_POL : ~VS_POL;
            blank       <= active_now;
            pix_x       <= active_now ? PX_W'(hc - HC_W'(HSTART)) : '0;
            pix_y       <= active_now ? PY_W'(vc - VC_W'(VSTART)) : '0;
            frame_start <= first_now;
        end
    end

endmodule

// File: rtl/vga_stream_out.sv
// Streams pixels from a valid/ready source onto a VGA raster, locking each
// frame to the source's start-of-frame marker and counting stream errors.
module vga_stream_out
    import vga_pkg::*;
#(
    parameter int                    HDISP      = DEF_HDISP,
    parameter int                    VDISP      = DEF_VDISP,
    parameter int                    HFP        = DEF_HFP,
    parameter int                    HPULSE     = DEF_HPULSE,
    parameter int                    HBP        = DEF_HBP,
    parameter int                    VFP        = DEF_VFP,
    parameter int                    VPULSE     = DEF_VPULSE,
    parameter int                    VBP        = DEF_VBP,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter bit                    HS_POL     = DEF_HS_POL,
    parameter bit                    VS_POL     = DEF_VS_POL,
    parameter logic [DATA_WIDTH-1:0] FILL_COLOR = DATA_WIDTH'(DEF_FILL_COLOR)
) (
    input  logic                       pixel_clk,
    input  logic                       pixel_rst_n,
    input  logic                       enable,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_WIDTH-1:0]      s_data,
    input  logic                       s_sof,
    output logic                       HS,
    output logic                       VS,
    output logic                       BLANK,
    output logic [DATA_WIDTH-1:0]      RGB,
    output logic [$clog2(HDISP)-1:0]   pix_x,
    output logic [$clog2(VDISP)-1:0]   pix_y,
    output logic                       frame_start,
    output logic [15:0]                err_count
);

    logic          active_now;
    logic          first_now;
    stream_state_e state;
    stream_state_e state_next;
    logic          load;
    logic          err_evt;

    vga_timing #(
        .HDISP  (HDISP),
        .VDISP  (VDISP),
        .HFP    (HFP),
        .HPULSE (HPULSE),
        .HBP    (HBP),
        .VFP    (VFP),
        .VPULSE (VPULSE),
        .VBP    (VBP),
        .HS_POL (HS_POL),
        .VS_POL (VS_POL)
    ) u_timing (
        .pixel_clk   (pixel_clk),
        .pixel_rst_n (pixel_rst_n),
        .active_now  (active_now),
        .first_now   (first_now),
        .hs          (HS),
        .vs          (VS),
        .blank       (BLANK),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start)
    );

    // Handshake and error decisions for the pixel the counters point at now.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        load       = 1'b0;
        err_evt    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (enable) state_next = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                s_ready = !(s_valid && s_sof);
                if (s_valid && s_sof) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (first_now) begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        load       = 1'b1;
                        state_next = ST_RUN;
                    end else begin
                        err_evt    = 1'b1;
                        state_next = ST_WAIT_SOF;
                    end
                end
            end
            ST_RUN: begin
                if (active_now) begin
                    if (!s_valid) begin
                        err_evt    = 1'b1;
                        state_next = ST_WAIT_SOF;
                    end else if (first_now && !s_sof) begin
                        s_ready    = 1'b1;
                        err_evt    = 1'b1;
                        state_next = ST_WAIT_SOF;
                    end else if (!first_now && s_sof) begin
                        // Early SOF is left on the bus and shown from the next frame origin.
                        err_evt    = 1'b1;
                        state_next = ST_ARMED;
                    end else begin
                        s_ready = 1'b1;
                        load    = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (!enable) begin
            state_next = ST_IDLE;
            s_ready    = 1'b0;
            load       = 1'b0;
            err_evt    = 1'b0;
        end
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            state     <= ST_IDLE;
            RGB       <= '0;
            err_count <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                RGB <= s_data;
            end else if (active_now) begin
                RGB <= FILL_COLOR;
            end else begin
                RGB <= '0;
            end
            if (err_evt && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_stream_out.sv
// Randomized bench for vga_stream_out on a 4x3 raster (7x6 totals, 42-cycle frame).
module tb_vga_stream_out;

    localparam int             DW    = 16;
    localparam logic [DW-1:0]  FILL  = 16'hA5C3;
    localparam int             HT    = 7;
    localparam int             FRAME = 42;
    localparam int             HS0   = 3;
    localparam int             VS0   = 3;
    localparam int             NPIX  = 12;

    logic           pixel_clk = 1'b0;
    logic           pixel_rst_n;
    logic           enable;
    logic           s_valid;
    logic           s_ready;
    logic [DW-1:0]  s_data;
    logic           s_sof;
    logic           HS;
    logic           VS;
    logic           BLANK;
    logic [DW-1:0]  RGB;
    logic [1:0]     pix_x;
    logic [1:0]     pix_y;
    logic           frame_start;
    logic [15:0]    err_count;

    vga_stream_out #(
        .HDISP      (4),
        .VDISP      (3),
        .HFP        (1),
        .HPULSE     (1),
        .HBP        (1),
        .VFP        (1),
        .VPULSE     (1),
        .VBP        (1),
        .DATA_WIDTH (DW),
        .HS_POL     (1'b0),
        .VS_POL     (1'b0),
        .FILL_COLOR (FILL)
    ) dut (
        .pixel_clk   (pixel_clk),
        .pixel_rst_n (pixel_rst_n),
        .enable      (enable),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_sof       (s_sof),
        .HS          (HS),
        .VS          (VS),
        .BLANK       (BLANK),
        .RGB         (RGB),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .err_count   (err_count)
    );

    always #5 pixel_clk = ~pixel_clk;

    int            errors = 0;
    int            checks = 0;
    int            pos    = 0;      // raster position the next rising edge acts on
    int            gap_pos = -1;    // position at which the source withholds valid
    logic [DW-1:0] q_data[$];
    bit            q_sof[$];
    logic [DW-1:0] cap[NPIX];
    logic [DW-1:0] exp_pix[NPIX];
    bit            ready_log[FRAME];
    int            fs_seen;
    int            blank_seen;

    // One pixel clock: drive the source, note the handshake, then compare the
    // registered outputs against the raster rules for the position just used.
    task automatic tick();
        bit         fire;
        int         p;
        int         hc;
        int         vc;
        bit         act;
        logic [3:0] exp_t;
        logic [3:0] got_t;
        logic [3:0] exp_p;
        s_valid = (q_data.size() != 0) && (pos != gap_pos);
        if (q_data.size() != 0) begin
            s_data = q_data[0];
            s_sof  = q_sof[0];
        end else begin
            s_data = '0;
            s_sof  = 1'b0;
        end
        #1;
        ready_log[pos] = (s_ready === 1'b1);
        fire = s_valid && (s_ready === 1'b1);
        @(posedge pixel_clk);
        p   = pos;
        pos = (pos + 1) % FRAME;
        if (fire) begin
            void'(q_data.pop_front());
            void'(q_sof.pop_front());
        end
        #2;
        hc    = p % HT;
        vc    = p / HT;
        act   = (hc >= HS0) && (vc >= VS0);
        exp_t = {hc != 1, vc != 1, act, (hc == HS0) && (vc == VS0)};
        got_t = {HS, VS, BLANK, frame_start};
        checks++;
        if (got_t !== exp_t) begin
            errors++;
            $display("FAIL timing pos=%0d HS,VS,BLANK,frame_start got %b expected %b", p, got_t, exp_t);
        end
        if (frame_start === 1'b1) fs_seen++;
        if (BLANK === 1'b1) blank_seen++;
        if (act) begin
            exp_p = {2'(hc - HS0), 2'(vc - VS0)};
            checks++;
            if ({pix_x, pix_y} !== exp_p) begin
                errors++;
                $display("FAIL coords pos=%0d got x,y=%b expected %b", p, {pix_x, pix_y}, exp_p);
            end
            cap[(vc - VS0) * 4 + (hc - HS0)] = RGB;
        end else begin
            checks++;
            if (RGB !== '0) begin
                errors++;
                $display("FAIL blank_rgb pos=%0d got %h expected 0", p, RGB);
            end
        end
    endtask

    task automatic run_frame();
        fs_seen    = 0;
        blank_seen = 0;
        for (int i = 0; i < NPIX; i++) cap[i] = 'x;
        for (int i = 0; i < FRAME; i++) tick();
    endtask

    task automatic run_until(input int p);
        for (int i = 0; i < FRAME && pos != p; i++) tick();
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input bit sof);
        q_data.push_back(d);
        q_sof.push_back(sof);
    endtask

    task automatic do_reset();
        pixel_rst_n = 1'b0;
        enable      = 1'b0;
        @(posedge pixel_clk);
        #2;
        q_data.delete();
        q_sof.delete();
        gap_pos     = -1;
        pixel_rst_n = 1'b1;
        pos         = 0;
    endtask

    task automatic test_reset();
        pixel_rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, BLANK, HS, VS, frame_start, pix_x, pix_y} !== 9'b001100000) begin
            errors++;
            $display("FAIL reset_sync got %b expected 001100000", {s_ready, BLANK, HS, VS, frame_start, pix_x, pix_y});
        end
        checks++;
        if ({RGB, err_count} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got RGB=%h err=%h expected 0", RGB, err_count);
        end
        do_reset();
    endtask

    task automatic test_idle_timing();
        bit any_ready;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            run_frame();
            any_ready = 1'b0;
            foreach (ready_log[i]) any_ready |= ready_log[i];
            checks++;
            if (any_ready) begin
                errors++;
                $display("FAIL idle_ready got s_ready=1 expected 0");
            end
            checks++;
            if (blank_seen != NPIX) begin
                errors++;
                $display("FAIL idle_blank_count got %0d expected %0d", blank_seen, NPIX);
            end
            for (int i = 0; i < NPIX; i++) begin
                checks++;
                if (cap[i] !== FILL) begin
                    errors++;
                    $display("FAIL idle_fill px=%0d got %h expected %h", i, cap[i], FILL);
                end
            end
        end
    endtask

    task automatic test_stream();
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            exp_pix[i] = DW'($urandom);
            push_beat(exp_pix[i], i == 0);
        end
        run_frame();
        enable = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (cap[i] !== exp_pix[i]) begin
                errors++;
                $display("FAIL stream_px px=%0d got %h expected %h", i, cap[i], exp_pix[i]);
            end
        end
        checks++;
        if (fs_seen != 1) begin
            errors++;
            $display("FAIL stream_frame_start got %0d pulses expected 1", fs_seen);
        end
        checks++;
        if (err_count !== 16'd0) begin
            errors++;
            $display("FAIL stream_err got %0d expected 0", err_count);
        end
    endtask

    // Source stalls at pixel (2,1); the rest of that frame is dropped until the next SOF.
    task automatic test_underflow();
        logic [DW-1:0] b[NPIX];
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            exp_pix[i] = DW'($urandom);
            push_beat(exp_pix[i], i == 0);
        end
        for (int i = 0; i < NPIX; i++) begin
            b[i] = DW'($urandom);
            push_beat(b[i], i == 0);
        end
        for (int i = 6; i < NPIX; i++) exp_pix[i] = FILL;
        gap_pos = 4 * HT + 5;
        run_frame();
        gap_pos = -1;
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (cap[i] !== exp_pix[i]) begin
                errors++;
                $display("FAIL underflow_frame px=%0d got %h expected %h", i, cap[i], exp_pix[i]);
            end
        end
        run_frame();
        enable = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (cap[i] !== b[i]) begin
                errors++;
                $display("FAIL underflow_next px=%0d got %h expected %h", i, cap[i], b[i]);
            end
        end
        checks++;
        if (err_count !== 16'd1) begin
            errors++;
            $display("FAIL underflow_err got %0d expected 1", err_count);
        end
    endtask

    // A new SOF arrives at pixel (1,0): it waits on the bus for the next frame origin.
    task automatic test_misaligned_sof();
        logic [DW-1:0] a0;
        do_reset();
        enable = 1'b1;
        a0 = DW'($urandom);
        push_beat(a0, 1'b1);
        for (int i = 0; i < NPIX; i++) begin
            exp_pix[i] = DW'($urandom);
            push_beat(exp_pix[i], i == 0);
        end
        run_frame();
        checks++;
        if (ready_log[HS0 + 1 + VS0 * HT]) begin
            errors++;
            $display("FAIL early_sof_ready got s_ready=1 expected 0");
        end
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (cap[i] !== ((i == 0) ? a0 : FILL)) begin
                errors++;
                $display("FAIL early_sof_frame px=%0d got %h expected %h", i, cap[i], (i == 0) ? a0 : FILL);
            end
        end
        run_frame();
        enable = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (cap[i] !== exp_pix[i]) begin
                errors++;
                $display("FAIL early_sof_next px=%0d got %h expected %h", i, cap[i], exp_pix[i]);
            end
        end
        checks++;
        if (err_count !== 16'd1) begin
            errors++;
            $display("FAIL early_sof_err got %0d expected 1", err_count);
        end
    endtask

    // Three stray beats drain while waiting for SOF; the SOF beat is held until (0,0).
    task automatic test_drop_before_sof();
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) push_beat(DW'($urandom), 1'b0);
        for (int i = 0; i < NPIX; i++) begin
            exp_pix[i] = DW'($urandom);
            push_beat(exp_pix[i], i == 0);
        end
        run_frame();
        enable = 1'b0;
        checks++;
        if ({ready_log[1], ready_log[2], ready_log[3], ready_log[4], ready_log[VS0 * HT + HS0]} !== 5'b11101) begin
            errors++;
            $display("FAIL drop_ready got %b expected 11101",
                     {ready_log[1], ready_log[2], ready_log[3], ready_log[4], ready_log[VS0 * HT + HS0]});
        end
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (cap[i] !== exp_pix[i]) begin
                errors++;
                $display("FAIL drop_frame px=%0d got %h expected %h", i, cap[i], exp_pix[i]);
            end
        end
        checks++;
        if (err_count !== 16'd0) begin
            errors++;
            $display("FAIL drop_err got %0d expected 0", err_count);
        end
    endtask

    task automatic test_reset_saturate();
        logic [15:0] exp_err;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < NPIX; i++) push_beat(DW'($urandom), i == 0);
        run_until(30);
        pixel_rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, BLANK, HS, VS, frame_start, pix_x, pix_y} !== 9'b001100000) begin
            errors++;
            $display("FAIL midrun_reset_sync got %b expected 001100000", {s_ready, BLANK, HS, VS, frame_start, pix_x, pix_y});
        end
        checks++;
        if (RGB !== '0) begin
            errors++;
            $display("FAIL midrun_reset_rgb got %h expected 0", RGB);
        end
        @(posedge pixel_clk);
        #2;
        q_data.delete();
        q_sof.delete();
        pixel_rst_n = 1'b1;
        pos = 0;
        force dut.err_count = 16'hFFFE;
        #1;
        release dut.err_count;
        exp_err = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            push_beat(DW'($urandom), 1'b1);
            run_frame();
            exp_err = (exp_err == 16'hFFFF) ? exp_err : exp_err + 16'd1;
            checks++;
            if (err_count !== exp_err) begin
                errors++;
                $display("FAIL saturate_err round=%0d got %h expected %h", k, err_count, exp_err);
            end
            checks++;
            if (cap[1] !== FILL) begin
                errors++;
                $display("FAIL saturate_fill round=%0d got %h expected %h", k, cap[1], FILL);
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        pixel_rst_n = 1'b1;
        enable      = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        s_sof       = 1'b0;
        #1;
        test_reset();
        test_idle_timing();
        test_stream();
        test_underflow();
        test_misaligned_sof();
        test_drop_before_sof();
        test_reset_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
